ping_pong_controller: RTL
=========================

Name: ping_pong_controller

Overview:
- Sequencing master for the cur/next character FIFO pair in the coprocessor.
- Owns `cur_is_even_character`. Seeds the initial thread into the current-character FIFO.
- Detects when the current character's work has drained, then swaps the parity and advances the character index. Terminates on end of string, on no surviving threads, or on abort.

Parameters:
- DATA_WIDTH, 16, width of a thread token (PC) pushed into the current FIFO at seed.
- COUNT_WIDTH, 6, width of FIFO occupancy counts.
- CHAR_ADDR_WIDTH, 16, width of character index and string length.
- SETTLE_CYCLES, 2, consecutive drained cycles required before a swap; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- start  in  1  one-cycle pulse; begins a match, accepted only in IDLE
- abort  in  1  level; forces termination
- str_len  in  CHAR_ADDR_WIDTH  string length in characters; sampled on start
- engines_busy  in  1  any execution engine holds an in-flight thread
- fifo_cur_char_data_out_valid  in  1  current FIFO non-empty
- fifo_cur_char_data_count  in  COUNT_WIDTH  current FIFO occupancy
- fifo_next_char_data_count  in  COUNT_WIDTH  next FIFO occupancy
- cur_is_even_character  out  1  parity select to the ping-pong buffer
- seed_data  out  DATA_WIDTH  initial thread token, constant 0
- seed_valid  out  1  seed push request into the current FIFO
- seed_ready  in  1  current FIFO ready (fifo_cur_char_data_in_ready)
- cur_char_index  out  CHAR_ADDR_WIDTH  index of the character being processed
- advance  out  1  one-cycle pulse on each swap
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE
- end_reached  out  1  in DONE: terminated at end of string
- no_thread  out  1  in DONE: terminated with empty next FIFO
- aborted  out  1  in DONE: terminated by abort

Behaviour:
- Reset (rst=0, any time, asynchronous):
  - state=IDLE.
  - cur_is_even_character=1, cur_char_index=0, settle counter=0.
  - All other outputs 0.
  - Mid-operation reset discards all state; no partial pulses.
- States: IDLE, SEED, RUN, SWAP, DONE.
- IDLE:
  - start=1 latches str_len.
  - If str_len==0: go to DONE with end_reached=1.
  - Otherwise: go to SEED. cur_is_even_character=1 and cur_char_index=0.
- SEED:
  - seed_valid=1 and seed_data=0 held until seed_ready=1. The transfer happens on that cycle; next state is RUN.
  - seed_valid never drops without the handshake, except on abort.
- RUN:
  - drained = !fifo_cur_char_data_out_valid && fifo_cur_char_data_count==0 && !engines_busy.
  - Settle counter increments while drained and clears on any cycle not drained.
  - When the counter reaches SETTLE_CYCLES, go to SWAP.
  - Minimum RUN-to-SWAP latency is SETTLE_CYCLES cycles.
- SWAP (exactly one cycle), in priority order:
  1. If cur_char_index+1 == latched str_len: go to DONE, end_reached=1.
  2. Else if fifo_next_char_data_count==0: go to DONE, no_thread=1.
  3. Else:
     - Toggle cur_is_even_character.
     - cur_char_index += 1; wrap is impossible because str_len ≤ 2^CHAR_ADDR_WIDTH−1.
     - advance=1 for this cycle.
     - Clear the settle counter and return to RUN.
  - Index and parity update registered at the end of SWAP, so new values are visible the cycle after the advance pulse.
- DONE:
  - done=1, and exactly one of end_reached / no_thread / aborted is 1.
  - Outputs held until the next start; that start clears all flags and is processed as in IDLE.
- abort:
  - abort=1 in SEED, RUN or SWAP goes to DONE with aborted=1 next cycle; seed_valid drops.
  - abort has priority over SWAP decisions.
  - abort is ignored in IDLE and DONE.
- start:
  - start while busy is ignored.
  - start together with abort in IDLE: start wins.
- busy = state ∈ {SEED, RUN, SWAP}.

Optional Feature:
- PPC_STATS_EN defined:
  - Adds output swap_count (CHAR_ADDR_WIDTH) and output drain_cycles (32).
  - swap_count counts advance pulses.
  - drain_cycles counts cycles spent in RUN with drained=0; saturates at all-ones.
  - Both clear on reset and on an accepted start; both hold in DONE.
- PPC_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- start, str_len=0 -> DONE next cycle: end_reached=1, seed_valid never asserted, cur_char_index=0.
- str_len=3, seed_ready held 0 for 4 cycles then 1 -> seed_valid=1 and seed_data=0 for 5 cycles, handshake on 5th cycle, then RUN.
- str_len=3, next count=2 at each swap, SETTLE_CYCLES=2:
  - Two advance pulses; parity 1→0→1; index 0→1→2.
  - Then DONE with end_reached=1.
  - Each swap occurs exactly 2 cycles after drained goes high.
- drained high 1 cycle, then engines_busy pulses, then drained again -> settle counter restarts; SWAP only after 2 uninterrupted drained cycles.
- str_len=5, next count=0 at first SWAP -> DONE with no_thread=1, no advance pulse, parity stays 1.
- abort during RUN at index 2 -> DONE next cycle with aborted=1. Async rst=0 mid-RUN -> all outputs 0 and parity 1 immediately, without a clock edge.

Source files
------------

// File: rtl/ping_pong_controller_if.sv
// Handshake/status bundle between the ping-pong sequencing master and its environment.
// The PPC_STATS_EN macro adds the swap_count and drain_cycles statistics signals.
interface ping_pong_controller_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int COUNT_WIDTH     = 6,
  parameter int CHAR_ADDR_WIDTH = 16
);
  logic                       start;
  logic                       abort;
  logic [CHAR_ADDR_WIDTH-1:0] str_len;
  logic                       engines_busy;
  logic                       fifo_cur_char_data_out_valid;
  logic [COUNT_WIDTH-1:0]     fifo_cur_char_data_count;
  logic [COUNT_WIDTH-1:0]     fifo_next_char_data_count;
  logic                       cur_is_even_character;
  logic [DATA_WIDTH-1:0]      seed_data;
  logic                       seed_valid;
  logic                       seed_ready;
  logic [CHAR_ADDR_WIDTH-1:0] cur_char_index;
  logic                       advance;
  logic                       busy;
  logic                       done;
  logic                       end_reached;
  logic                       no_thread;
  logic                       aborted;
`ifdef PPC_STATS_EN
  logic [CHAR_ADDR_WIDTH-1:0] swap_count;
  logic [31:0]                drain_cycles;
`endif

  modport master (
    input  start, abort, str_len, engines_busy, fifo_cur_char_data_out_valid,
           fifo_cur_char_data_count, fifo_next_char_data_count, seed_ready,
    output cur_is_even_character, seed_data, seed_valid, cur_char_index,
           advance, busy, done, end_reached, no_thread, aborted
`ifdef PPC_STATS_EN
    , output swap_count, drain_cycles
`endif
  );

  modport slave (
    output start, abort, str_len, engines_busy, fifo_cur_char_data_out_valid,
           fifo_cur_char_data_count, fifo_next_char_data_count, seed_ready,
    input  cur_is_even_character, seed_data, seed_valid, cur_char_index,
           advance, busy, done, end_reached, no_thread, aborted
`ifdef PPC_STATS_EN
    , input swap_count, drain_cycles
`endif
  );
endinterface

// File: rtl/ping_pong_controller.sv
// Sequencing master for the cur/next character FIFO pair: seeds the first thread,
// swaps parity once the current character drains. Optional stats under PPC_STATS_EN.
module ping_pong_controller #(
  parameter int DATA_WIDTH      = 16,
  parameter int COUNT_WIDTH     = 6,
  parameter int CHAR_ADDR_WIDTH = 16,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ping_pong_controller_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_SWAP, S_DONE} state_t;

  localparam logic [CHAR_ADDR_WIDTH-1:0] IDX_ONE   = CHAR_ADDR_WIDTH'(1);
  localparam logic [3:0]                 SETTLE_LIM = 4'(SETTLE_CYCLES);

  state_t                     r_state;
  logic [3:0]                 r_settle;
  logic [CHAR_ADDR_WIDTH-1:0] r_len;
  logic [CHAR_ADDR_WIDTH-1:0] r_idx;
  logic                       r_parity;
  logic                       r_seed_valid;
  logic                       r_done;
  logic                       r_end;
  logic                       r_no_thread;
  logic                       r_aborted;

  logic w_drained;
  logic w_last;
  logic w_accept;
  logic w_advance;

  assign w_drained = !bus.fifo_cur_char_data_out_valid &&
                     (bus.fifo_cur_char_data_count == '0) && !bus.engines_busy;
  assign w_last    = ((r_idx + IDX_ONE) == r_len);
  assign w_accept  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Abort in SWAP pre-empts the swap, so the pulse must be qualified by it too.
  assign w_advance = (r_state == S_SWAP) && !bus.abort && !w_last &&
                     (bus.fifo_next_char_data_count != '0);

  // String length is data; it is only meaningful after an accepted start.
  always_ff @(posedge clk) begin
    if (w_accept) r_len <= bus.str_len;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_settle     <= '0;
      r_idx        <= '0;
      r_parity     <= 1'b1;
      r_seed_valid <= 1'b0;
      r_done       <= 1'b0;
      r_end        <= 1'b0;
      r_no_thread  <= 1'b0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_end       <= 1'b0;
            r_no_thread <= 1'b0;
            r_aborted   <= 1'b0;
            r_idx       <= '0;
            r_parity    <= 1'b1;
            r_settle    <= '0;
            if (bus.str_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_end   <= 1'b1;
            end else begin
              r_state      <= S_SEED;
              r_done       <= 1'b0;
              r_seed_valid <= 1'b1;
            end
          end
        end
        S_SEED, S_RUN, S_SWAP: begin
          if (bus.abort) begin
            r_state      <= S_DONE;
            r_done       <= 1'b1;
            r_aborted    <= 1'b1;
            r_seed_valid <= 1'b0;
            r_settle     <= '0;
          end else if (r_state == S_SEED) begin
            if (bus.seed_ready) begin
              r_seed_valid <= 1'b0;
              r_settle     <= '0;
              r_state      <= S_RUN;
            end
          end else if (r_state == S_RUN) begin
            if (!w_drained) begin
              r_settle <= '0;
            end else if ((r_settle + 4'd1) == SETTLE_LIM) begin
              r_settle <= '0;
              r_state  <= S_SWAP;
            end else begin
              r_settle <= r_settle + 4'd1;
            end
          end else if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_end   <= 1'b1;
          end else if (bus.fifo_next_char_data_count == '0) begin
            r_state     <= S_DONE;
            r_done      <= 1'b1;
            r_no_thread <= 1'b1;
          end else begin
            r_parity <= ~r_parity;
            r_idx    <= r_idx + IDX_ONE;
            r_settle <= '0;
            r_state  <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PPC_STATS_EN
  logic [CHAR_ADDR_WIDTH-1:0] r_swap_count;
  logic [31:0]                r_drain_cycles;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_swap_count   <= '0;
      r_drain_cycles <= '0;
    end else if (w_accept) begin
      r_swap_count   <= '0;
      r_drain_cycles <= '0;
    end else begin
      if (w_advance) r_swap_count <= r_swap_count + IDX_ONE;
      if ((r_state == S_RUN) && !w_drained && (r_drain_cycles != '1))
        r_drain_cycles <= r_drain_cycles + 32'd1;
    end
  end

  assign bus.swap_count   = r_swap_count;
  assign bus.drain_cycles = r_drain_cycles;
`endif

  assign bus.cur_is_even_character = r_parity;
  assign bus.seed_data             = '0;
  assign bus.seed_valid            = r_seed_valid;
  assign bus.cur_char_index        = r_idx;
  assign bus.advance               = w_advance;
  assign bus.busy                  = (r_state == S_SEED) || (r_state == S_RUN) ||
                                     (r_state == S_SWAP);
  assign bus.done                  = r_done;
  assign bus.end_reached           = r_end;
  assign bus.no_thread             = r_no_thread;
  assign bus.aborted               = r_aborted;

endmodule
